// File: rtl/decode_pkg.sv
// Shared types and constants for the DECODE stage of the 16-bit pipeline.
// Instruction word layout: [15:12] opcode, [11:8] dst, [7:4] src, [3:0] mode.
package decode_pkg;

   localparam int unsigned WORD_W = 16;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_MOV = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_AND = 4'h4;
   localparam logic [3:0] OP_OR  = 4'h5;
   localparam logic [3:0] OP_XOR = 4'h6;
   localparam logic [3:0] OP_LD  = 4'h7;
   localparam logic [3:0] OP_ST  = 4'h8;
   localparam logic [3:0] OP_JMP = 4'hF;

   localparam logic [3:0] MODE_REG = 4'h0;
   localparam logic [3:0] MODE_IMM = 4'h1;

   typedef enum logic [1:0] {
      RESET_PC = 2'd0,
      IDLE     = 2'd1,
      WAIT_IMM = 2'd2,
      REDIRECT = 2'd3
   } state_e;

   typedef struct packed {
      logic [3:0] opcode;
      logic [3:0] dst;
      logic [3:0] src;
      logic [3:0] mode;
   } instr_t;

   // Only mode 1 pulls in a second word; every other mode decodes as register form.
   function automatic logic has_imm(input instr_t ins);
      return ins.mode == MODE_IMM;
   endfunction

endpackage

// File: rtl/decode.sv
// DECODE stage: accepts words from FETCH, gathers an optional immediate and
// emits one registered micro-op to EXECUTE; owns post-reset and JMP redirects.
//
// state    | meaning
// RESET_PC | first cycle out of reset, drives RESET_ADDR to FETCH
// IDLE     | waiting for an opcode word
// WAIT_IMM | opcode latched, waiting for its immediate word
// REDIRECT | drives the immediate JMP target to FETCH, drops any offered word
module decode
   import decode_pkg::*;
#(
   parameter logic [15:0] RESET_ADDR = 16'h0000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        fe_valid_i,
   output logic        fe_ready_o,
   input  logic [15:0] fe_addr_i,
   input  logic [15:0] fe_data_i,
   output logic        fe_valid_o,
   output logic [15:0] fe_addr_o,
   output logic        ex_valid_o,
   input  logic        ex_ready_i,
   output logic [15:0] ex_addr_o,
   output logic [3:0]  ex_opcode_o,
   output logic [3:0]  ex_dst_o,
   output logic [3:0]  ex_src_o,
   output logic        ex_imm_valid_o,
   output logic [15:0] ex_imm_o
);

   state_e      state_q;
   instr_t      word;
   logic        xfer;
   logic        out_free;

   logic [15:0] hold_addr_q;
   logic [3:0]  hold_op_q;
   logic [3:0]  hold_dst_q;
   logic [3:0]  hold_src_q;
   logic [15:0] target_q;

   logic        ex_valid_q;
   logic [15:0] ex_addr_q;
   logic [3:0]  ex_opcode_q;
   logic [3:0]  ex_dst_q;
   logic [3:0]  ex_src_q;
   logic        ex_imm_valid_q;
   logic [15:0] ex_imm_q;

   assign word     = instr_t'(fe_data_i);
   assign out_free = !ex_valid_q || ex_ready_i;

   assign fe_ready_o = ((state_q == IDLE) || (state_q == WAIT_IMM)) && out_free;
   assign xfer       = fe_valid_i && fe_ready_o;

   // RESET_PC is also the state held during reset, so gate its strobe until rst_ni is released.
   assign fe_valid_o = (state_q == REDIRECT) || ((state_q == RESET_PC) && rst_ni);
   assign fe_addr_o  = !fe_valid_o             ? 16'h0000 :
                       (state_q == REDIRECT)   ? target_q : RESET_ADDR;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q        <= RESET_PC;
         hold_addr_q    <= '0;
         hold_op_q      <= '0;
         hold_dst_q     <= '0;
         hold_src_q     <= '0;
         target_q       <= '0;
         ex_valid_q     <= 1'b0;
         ex_addr_q      <= '0;
         ex_opcode_q    <= '0;
         ex_dst_q       <= '0;
         ex_src_q       <= '0;
         ex_imm_valid_q <= 1'b0;
         ex_imm_q       <= '0;
      end else begin
         if (ex_ready_i) begin
            ex_valid_q <= 1'b0;
         end
         unique case (state_q)
            RESET_PC: begin
               state_q <= IDLE;
            end
            IDLE: begin
               if (xfer) begin
                  if (has_imm(word)) begin
                     hold_addr_q <= fe_addr_i;
                     hold_op_q   <= word.opcode;
                     hold_dst_q  <= word.dst;
                     hold_src_q  <= word.src;
                     state_q     <= WAIT_IMM;
                  end else begin
                     // Register-form JMP goes out as a normal micro-op; EXECUTE resolves it.
                     ex_valid_q     <= 1'b1;
                     ex_addr_q      <= fe_addr_i;
                     ex_opcode_q    <= word.opcode;
                     ex_dst_q       <= word.dst;
                     ex_src_q       <= word.src;
                     ex_imm_valid_q <= 1'b0;
                     ex_imm_q       <= '0;
                  end
               end
            end
            WAIT_IMM: begin
               if (xfer) begin
                  if (hold_op_q == OP_JMP) begin
                     target_q <= fe_data_i;
                     state_q  <= REDIRECT;
                  end else begin
                     ex_valid_q     <= 1'b1;
                     ex_addr_q      <= hold_addr_q;
                     ex_opcode_q    <= hold_op_q;
                     ex_dst_q       <= hold_dst_q;
                     ex_src_q       <= hold_src_q;
                     ex_imm_valid_q <= 1'b1;
                     ex_imm_q       <= fe_data_i;
                     state_q        <= IDLE;
                  end
               end
            end
            REDIRECT: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= RESET_PC;
            end
         endcase
      end
   end

   assign ex_valid_o     = ex_valid_q;
   assign ex_addr_o      = ex_addr_q;
   assign ex_opcode_o    = ex_opcode_q;
   assign ex_dst_o       = ex_dst_q;
   assign ex_src_o       = ex_src_q;
   assign ex_imm_valid_o = ex_imm_valid_q;
   assign ex_imm_o       = ex_imm_q;

   // Interface properties shared with the FETCH-side formal wrapper.
   a_stall_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (ex_valid_o && !ex_ready_i) |=>
      $stable({ex_valid_o, ex_addr_o, ex_opcode_o, ex_dst_o, ex_src_o, ex_imm_valid_o, ex_imm_o}));

   a_fe_valid_pulse : assert property (@(posedge clk_i) disable iff (!rst_ni)
      fe_valid_o |=> !fe_valid_o);

   a_reset_pc : assert property (@(posedge clk_i)
      $rose(rst_ni) |-> (fe_valid_o && (fe_addr_o == RESET_ADDR)));

endmodule

// File: tb/tb_decode.sv
// Scoreboard bench for DECODE: expected micro-ops are queued as words are
// offered and checked when EXECUTE accepts them; handshake checks are inline.
module tb_decode;

   typedef struct packed {
      logic [15:0] addr;
      logic [3:0]  op;
      logic [3:0]  dst;
      logic [3:0]  src;
      logic        immv;
      logic [15:0] imm;
   } uop_t;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        fe_valid_i = 1'b0;
   logic        fe_ready_o;
   logic [15:0] fe_addr_i = '0;
   logic [15:0] fe_data_i = '0;
   logic        fe_valid_o;
   logic [15:0] fe_addr_o;
   logic        ex_valid_o;
   logic        ex_ready_i = 1'b1;
   logic [15:0] ex_addr_o;
   logic [3:0]  ex_opcode_o;
   logic [3:0]  ex_dst_o;
   logic [3:0]  ex_src_o;
   logic        ex_imm_valid_o;
   logic [15:0] ex_imm_o;

   int   n_vec  = 0;
   int   n_miss = 0;
   uop_t sb[$];
   uop_t mon_exp;
   uop_t got;

   decode #(.RESET_ADDR(16'h0100)) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .fe_valid_i     (fe_valid_i),
      .fe_ready_o     (fe_ready_o),
      .fe_addr_i      (fe_addr_i),
      .fe_data_i      (fe_data_i),
      .fe_valid_o     (fe_valid_o),
      .fe_addr_o      (fe_addr_o),
      .ex_valid_o     (ex_valid_o),
      .ex_ready_i     (ex_ready_i),
      .ex_addr_o      (ex_addr_o),
      .ex_opcode_o    (ex_opcode_o),
      .ex_dst_o       (ex_dst_o),
      .ex_src_o       (ex_src_o),
      .ex_imm_valid_o (ex_imm_valid_o),
      .ex_imm_o       (ex_imm_o)
   );

   always #5 clk_i = ~clk_i;

   assign got = '{ex_addr_o, ex_opcode_o, ex_dst_o, ex_src_o, ex_imm_valid_o, ex_imm_o};

   // Every accepted micro-op must match the oldest queued expectation.
   always @(negedge clk_i) begin
      if (rst_ni && ex_valid_o && ex_ready_i) begin
         n_vec++;
         if (sb.size() == 0) begin
            n_miss++;
            $display("FAIL uop_unexpected: got %h, expected no micro-op", got);
         end else begin
            mon_exp = sb.pop_front();
            if (got !== mon_exp) begin
               n_miss++;
               $display("FAIL uop_fields: got %h, expected %h", got, mon_exp);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic mid();
      @(negedge clk_i);
   endtask

   function automatic uop_t reg_uop(input logic [15:0] a, input logic [15:0] w);
      return '{a, w[15:12], w[11:8], w[7:4], 1'b0, 16'h0000};
   endfunction

   task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] d);
      fe_valid_i = v;
      fe_addr_i  = a;
      fe_data_i  = d;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      drive(1'b0, 16'h0, 16'h0);
      ex_ready_i = 1'b1;
      repeat (3) step();
      mid();
      n_vec++;
      if ({fe_valid_o, fe_ready_o, ex_valid_o, fe_addr_o} !== 19'h0) begin
         n_miss++;
         $display("FAIL reset_hold: got fv=%b fr=%b ev=%b fa=%h, expected all 0",
                  fe_valid_o, fe_ready_o, ex_valid_o, fe_addr_o);
      end
      step();
      rst_ni = 1'b1;
      mid();
      n_vec++;
      if ({fe_valid_o, fe_addr_o, fe_ready_o, ex_valid_o} !== {1'b1, 16'h0100, 1'b0, 1'b0}) begin
         n_miss++;
         $display("FAIL reset_pc: got fv=%b fa=%h fr=%b ev=%b, expected fv=1 fa=0100 fr=0 ev=0",
                  fe_valid_o, fe_addr_o, fe_ready_o, ex_valid_o);
      end
      step();
      mid();
      n_vec++;
      if ({fe_valid_o, fe_addr_o, fe_ready_o} !== {1'b0, 16'h0000, 1'b1}) begin
         n_miss++;
         $display("FAIL reset_pc_once: got fv=%b fa=%h fr=%b, expected fv=0 fa=0000 fr=1",
                  fe_valid_o, fe_addr_o, fe_ready_o);
      end
   endtask

   task automatic test_reg_op();
      step();
      drive(1'b1, 16'h0100, 16'h1230);
      sb.push_back(reg_uop(16'h0100, 16'h1230));
      mid();
      n_vec++;
      if (fe_ready_o !== 1'b1) begin
         n_miss++;
         $display("FAIL reg_ready: got %b, expected 1", fe_ready_o);
      end
      step();
      drive(1'b0, 16'h0, 16'h0);
      mid();
      n_vec++;
      if ({ex_valid_o, ex_imm_valid_o} !== 2'b10) begin
         n_miss++;
         $display("FAIL reg_latency: got ev=%b iv=%b, expected ev=1 iv=0", ex_valid_o, ex_imm_valid_o);
      end
   endtask

   task automatic test_imm_op();
      step();
      drive(1'b1, 16'h0102, 16'h2451);
      mid();
      step();
      drive(1'b1, 16'h0104, 16'hBEEF);
      sb.push_back('{16'h0102, 4'h2, 4'h4, 4'h5, 1'b1, 16'hBEEF});
      mid();
      n_vec++;
      if ({ex_valid_o, fe_ready_o} !== 2'b01) begin
         n_miss++;
         $display("FAIL imm_wait: got ev=%b fr=%b, expected ev=0 fr=1", ex_valid_o, fe_ready_o);
      end
      step();
      drive(1'b0, 16'h0, 16'h0);
      mid();
      n_vec++;
      if (ex_valid_o !== 1'b1) begin
         n_miss++;
         $display("FAIL imm_latency: got ev=%b, expected 1", ex_valid_o);
      end
   endtask

   task automatic test_jmp();
      step();
      drive(1'b1, 16'h0106, 16'hF001);
      mid();
      step();
      drive(1'b1, 16'h0108, 16'h4000);
      mid();
      n_vec++;
      if ({ex_valid_o, fe_ready_o} !== 2'b01) begin
         n_miss++;
         $display("FAIL jmp_imm_accept: got ev=%b fr=%b, expected ev=0 fr=1", ex_valid_o, fe_ready_o);
      end
      step();
      drive(1'b1, 16'h0300, 16'h1230);
      mid();
      n_vec++;
      if ({fe_valid_o, fe_addr_o, fe_ready_o, ex_valid_o} !== {1'b1, 16'h4000, 1'b0, 1'b0}) begin
         n_miss++;
         $display("FAIL jmp_redirect: got fv=%b fa=%h fr=%b ev=%b, expected fv=1 fa=4000 fr=0 ev=0",
                  fe_valid_o, fe_addr_o, fe_ready_o, ex_valid_o);
      end
      step();
      drive(1'b0, 16'h0, 16'h0);
      mid();
      n_vec++;
      if ({ex_valid_o, fe_valid_o, fe_addr_o} !== 18'h0) begin
         n_miss++;
         $display("FAIL jmp_drop: got ev=%b fv=%b fa=%h, expected all 0", ex_valid_o, fe_valid_o, fe_addr_o);
      end
   endtask

   task automatic test_stall();
      step();
      ex_ready_i = 1'b0;
      drive(1'b1, 16'h0200, 16'h3120);
      sb.push_back(reg_uop(16'h0200, 16'h3120));
      mid();
      n_vec++;
      if (fe_ready_o !== 1'b1) begin
         n_miss++;
         $display("FAIL stall_first_ready: got %b, expected 1", fe_ready_o);
      end
      step();
      drive(1'b1, 16'h0202, 16'h5670);
      for (int i = 0; i < 3; i++) begin
         if (i > 0) step();
         mid();
         n_vec++;
         if ({fe_ready_o, ex_valid_o, got} !== {1'b0, 1'b1, reg_uop(16'h0200, 16'h3120)}) begin
            n_miss++;
            $display("FAIL stall_hold[%0d]: got fr=%b ev=%b uop=%h, expected fr=0 ev=1 uop=%h",
                     i, fe_ready_o, ex_valid_o, got, reg_uop(16'h0200, 16'h3120));
         end
      end
      step();
      ex_ready_i = 1'b1;
      sb.push_back(reg_uop(16'h0202, 16'h5670));
      mid();
      n_vec++;
      if (fe_ready_o !== 1'b1) begin
         n_miss++;
         $display("FAIL stall_release_ready: got %b, expected 1", fe_ready_o);
      end
      step();
      drive(1'b0, 16'h0, 16'h0);
      mid();
      n_vec++;
      if (ex_valid_o !== 1'b1) begin
         n_miss++;
         $display("FAIL stall_reload: got ev=%b, expected 1", ex_valid_o);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] words [4];
      words[0] = 16'h7A9C;
      words[1] = 16'hF120;
      words[2] = 16'h8DE0;
      words[3] = 16'h9012;
      for (int i = 0; i < 4; i++) begin
         step();
         drive(1'b1, 16'h0300 + 16'(i), words[i]);
         sb.push_back(reg_uop(16'h0300 + 16'(i), words[i]));
         mid();
         n_vec++;
         if ({fe_ready_o, ex_valid_o} !== {1'b1, (i > 0)}) begin
            n_miss++;
            $display("FAIL b2b[%0d]: got fr=%b ev=%b, expected fr=1 ev=%b",
                     i, fe_ready_o, ex_valid_o, (i > 0));
         end
      end
      step();
      drive(1'b0, 16'h0, 16'h0);
      mid();
      step();
      mid();
      n_vec++;
      if ({ex_valid_o, 32'(sb.size())} !== 33'h0) begin
         n_miss++;
         $display("FAIL b2b_drain: got ev=%b pending=%0d, expected ev=0 pending=0", ex_valid_o, sb.size());
      end
   endtask

   task automatic test_reset_wait_imm();
      step();
      drive(1'b1, 16'h0500, 16'h2451);
      mid();
      step();
      drive(1'b0, 16'h0, 16'h0);
      rst_ni = 1'b0;
      mid();
      step();
      mid();
      n_vec++;
      if ({ex_valid_o, got, fe_valid_o, fe_addr_o, fe_ready_o} !== '0) begin
         n_miss++;
         $display("FAIL rst_mid_outputs: got ev=%b uop=%h fv=%b fa=%h fr=%b, expected all 0",
                  ex_valid_o, got, fe_valid_o, fe_addr_o, fe_ready_o);
      end
      step();
      rst_ni = 1'b1;
      mid();
      n_vec++;
      if ({fe_valid_o, fe_addr_o, ex_valid_o} !== {1'b1, 16'h0100, 1'b0}) begin
         n_miss++;
         $display("FAIL rst_mid_replay: got fv=%b fa=%h ev=%b, expected fv=1 fa=0100 ev=0",
                  fe_valid_o, fe_addr_o, ex_valid_o);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         mid();
         n_vec++;
         if ({ex_valid_o, fe_valid_o} !== 2'b00) begin
            n_miss++;
            $display("FAIL rst_mid_stale[%0d]: got ev=%b fv=%b, expected 0 0", i, ex_valid_o, fe_valid_o);
         end
      end
      step();
      drive(1'b1, 16'h0600, 16'h1230);
      sb.push_back(reg_uop(16'h0600, 16'h1230));
      mid();
      step();
      drive(1'b0, 16'h0, 16'h0);
      mid();
      n_vec++;
      if ({ex_valid_o, ex_imm_valid_o} !== 2'b10) begin
         n_miss++;
         $display("FAIL rst_mid_fresh: got ev=%b iv=%b, expected ev=1 iv=0", ex_valid_o, ex_imm_valid_o);
      end
   endtask

   initial begin
      test_reset();
      test_reg_op();
      test_imm_op();
      test_jmp();
      test_stall();
      test_back_to_back();
      test_reset_wait_imm();
      step();
      mid();
      n_vec++;
      if (sb.size() != 0) begin
         n_miss++;
         $display("FAIL sb_empty: got %0d pending micro-ops, expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/decode.md
Name: decode

Overview:
- DECODE stage of the 16-bit CPU pipeline. Sits directly downstream of FETCH and upstream of EXECUTE.
- Consumes instruction words from FETCH over a valid/ready handshake, collects an optional immediate word, and emits one decoded micro-op per instruction to EXECUTE.
- Owns PC redirection: after reset, and on every immediate-form JMP, it sends FETCH a new PC for exactly one cycle.

Parameters:
- RESET_ADDR, 16'h0000, PC sent to FETCH on the first cycle after reset.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset: synchronous and active-low. Sampled on the rising edge of clk_i.
- fe_valid_i  in  1  FETCH presents an instruction word.
- fe_ready_o  out  1  DECODE accepts the word this cycle.
- fe_addr_i  in  16  address of the presented word.
- fe_data_i  in  16  presented word.
- fe_valid_o  out  1  new-PC strobe to FETCH; one cycle wide.
- fe_addr_o  out  16  new PC; 0 when fe_valid_o is low.
- ex_valid_o  out  1  micro-op valid.
- ex_ready_i  in  1  EXECUTE accepts the micro-op.
- ex_addr_o  out  16  address of the opcode word.
- ex_opcode_o  out  4  opcode field.
- ex_dst_o  out  4  destination register.
- ex_src_o  out  4  source register.
- ex_imm_valid_o  out  1  ex_imm_o is used.
- ex_imm_o  out  16  immediate word; 0 if unused.

Behaviour:
- Instruction word fields: [15:12] opcode, [11:8] dst, [7:4] src, [3:0] mode.
  - mode 0: register operand.
  - mode 1: one immediate word follows.
  - modes 2..15: treated as mode 0.
  - Opcode F is JMP.
- A word transfers when fe_valid_i && fe_ready_o.
- fe_ready_o = (state==IDLE || state==WAIT_IMM) && (!ex_valid_o || ex_ready_i).
- States and transitions:
  - RESET_PC: entered while rst_ni=0. In the first cycle with rst_ni=1: fe_valid_o=1, fe_addr_o=RESET_ADDR, fe_ready_o=0. Goes to IDLE.
  - IDLE, on a transferred word:
    - mode 1: latch addr and fields, go to WAIT_IMM.
    - mode 0 with opcode F: emit the micro-op (register JMP is resolved in EXECUTE), stay in IDLE.
    - otherwise: load the output register, stay in IDLE.
  - WAIT_IMM, on a transferred word:
    - opcode F: latch the word as the jump target, go to REDIRECT. No micro-op is emitted.
    - otherwise: load the output register with the latched fields, imm_valid=1, imm=word. Go to IDLE.
  - REDIRECT: fe_valid_o=1, fe_addr_o=target, fe_ready_o=0; any word FETCH presents this cycle is dropped. Goes to IDLE.
- Latency: the micro-op's ex_valid_o rises the cycle after its last word transfers.
- Output register:
  - Holds all ex_* outputs stable while ex_valid_o && !ex_ready_i.
  - Clears ex_valid_o on ex_ready_i unless it is reloaded in the same cycle, which gives back-to-back throughput of one instruction per cycle.
- Reset: rst_ni=0 in any state, including mid-instruction or mid-stall, forces on the next edge:
  - ex_valid_o=0, ex_* fields=0, fe_valid_o=0, fe_addr_o=0, fe_ready_o=0.
  - Latched fields discarded; state=RESET_PC.
- fe_valid_o is never asserted in two consecutive cycles.
- No address arithmetic is required. fe_addr_i of the immediate word is not checked.

Decomposition:
- decode_pkg holds:
  - opcode constants; OP_JMP = 4'hF.
  - MODE_REG = 0, MODE_IMM = 1.
  - a state enum: RESET_PC, IDLE, WAIT_IMM, REDIRECT.
  - a packed instruction-field struct.
- No functional sub-module.
- A decode_formal wrapper, mirroring the FETCH one, carries the properties:
  - stability under stall;
  - one-cycle fe_valid_o;
  - fe_valid_o after reset.

Test Plan:
- Reset: release rst_ni with RESET_ADDR=16'h0100 -> fe_valid_o=1 and fe_addr_o=16'h0100 in the first cycle only, ex_valid_o=0.
- Register op: fe_data_i=16'h1230 @16'h0100, ex_ready_i=1 -> next cycle ex_valid_o=1, opcode=1, dst=2, src=3, ex_addr_o=16'h0100, ex_imm_valid_o=0.
- Immediate op: 16'h2451 then 16'hBEEF -> one micro-op with opcode=2, dst=4, src=5, imm=16'hBEEF, ex_addr_o=opcode word's address.
- Immediate JMP: 16'hF001 then 16'h4000 -> no ex_valid_o; next cycle fe_valid_o=1, fe_addr_o=16'h4000, fe_ready_o=0; the word FETCH presents in that cycle is dropped.
- Stall: ex_ready_i=0 for 3 cycles with ex_valid_o=1 -> ex_* outputs stable and fe_ready_o=0. When ex_ready_i rises, fe_ready_o=1 and a back-to-back word is reloaded in that cycle.
- Reset in WAIT_IMM: rst_ni=0 after 16'h2451 is accepted -> all outputs 0; after release RESET_PC replays and no stale micro-op appears.
